// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer and valid/ready handshakes on both sides.
// Optional retired-entry counter is enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_skid #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_alu,
    input  logic [n-1:0] in_mem,
    input  logic [n-1:0] in_pc4,
    input  logic [n-1:0] in_imm,
    input  logic [1:0]   in_wb_sel,
    input  logic [4:0]   in_rd,
    input  logic         in_reg_write,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_alu,
    output logic [n-1:0] out_mem,
    output logic [n-1:0] out_pc4,
    output logic [n-1:0] out_imm,
    output logic [1:0]   out_wb_sel,
    output logic [4:0]   out_rd,
`ifdef MEM_WB_RETIRE_CNT_EN
    output logic [31:0]  retired_cnt,
`endif
    output logic         out_reg_write
);

    typedef struct packed {
        logic         reg_write;
        logic [4:0]   rd;
        logic [1:0]   wb_sel;
        logic [n-1:0] imm;
        logic [n-1:0] pc4;
        logic [n-1:0] mem;
        logic [n-1:0] alu;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;

    always_comb begin
        in_entry           = '0;
        in_entry.reg_write = in_reg_write;
        in_entry.rd        = in_rd;
        in_entry.wb_sel    = in_wb_sel;
        in_entry.imm       = in_imm;
        in_entry.pc4       = in_pc4;
        in_entry.mem       = in_mem;
        in_entry.alu       = in_alu;
    end

    // in_ready is ~skid_valid, so an accept never coincides with a SKID->MAIN move.
    assign accept = in_valid & ~skid_valid & ~flush;
    assign drain  = ~main_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready      = ~skid_valid;
    assign out_valid     = main_valid;
    assign out_alu       = main_q.alu;
    assign out_mem       = main_q.mem;
    assign out_pc4       = main_q.pc4;
    assign out_imm       = main_q.imm;
    assign out_wb_sel    = main_q.wb_sel;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write & main_valid;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (!flush && main_valid && out_ready) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule
